// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_pkg
// Description : Shared definitions for the MAC sequencer and the post-MAC
//               bias/ReLU/shift stage: layer encodings, FSM state encoding
//               and default layer dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    // Layer select shared with the post-MAC stage; 2'b11 is never driven
    localparam logic [1:0] LAYER_CONV1 = 2'b00;
    localparam logic [1:0] LAYER_CONV2 = 2'b01;
    localparam logic [1:0] LAYER_FC    = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Default network dimensions
    localparam int c_L0_OUTS = 576;  // 24x24 conv1 positions, 6 channels per position
    localparam int c_L0_TAPS = 25;   // 5x5 kernel
    localparam int c_L1_OUTS = 64;   // conv2 positions
    localparam int c_L1_TAPS = 25;   // taps per lane, lanes summed downstream
    localparam int c_L2_OUTS = 2;    // FC groups of 6 lanes (10 logits)
    localparam int c_L2_TAPS = 192;  // FC inputs per output
    localparam int c_MAC_LAT = 2;    // last mac_en to valid MAC outputs
    localparam int c_TAP_W   = 8;
    localparam int c_OUT_W   = 10;

endpackage
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer
// Description : Control FSM stepping the shared 6-lane MAC array through
//               conv1, conv2 and FC. Per output: clear accumulators, stream
//               taps while operands are valid, wait out the MAC latency,
//               then issue one result write.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int L0_OUTS = c_L0_OUTS,
    parameter int L0_TAPS = c_L0_TAPS,
    parameter int L1_OUTS = c_L1_OUTS,
    parameter int L1_TAPS = c_L1_TAPS,
    parameter int L2_OUTS = c_L2_OUTS,
    parameter int L2_TAPS = c_L2_TAPS,
    parameter int MAC_LAT = c_MAC_LAT,
    parameter int TAP_W   = c_TAP_W,
    parameter int OUT_W   = c_OUT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [1:0]       mac_layer,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [TAP_W-1:0] tap_idx,
    output logic [OUT_W-1:0] out_idx,
    input  logic             op_valid,
    output logic             res_we,
    input  logic             res_rdy,
    output logic [OUT_W-1:0] res_addr
);

    // Drain counter only needs to reach MAC_LAT-1; keep at least one bit so
    // the MAC_LAT=0 build still elaborates (DRAIN is then unreachable).
    localparam int c_DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
        c_DRAIN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam state_t c_AFTER_ACCUM = (MAC_LAT == 0) ? WRITE : DRAIN;

    localparam logic [TAP_W-1:0] c_L0_TAP_LAST = TAP_W'(L0_TAPS - 1);
    localparam logic [TAP_W-1:0] c_L1_TAP_LAST = TAP_W'(L1_TAPS - 1);
    localparam logic [TAP_W-1:0] c_L2_TAP_LAST = TAP_W'(L2_TAPS - 1);
    localparam logic [OUT_W-1:0] c_L0_OUT_LAST = OUT_W'(L0_OUTS - 1);
    localparam logic [OUT_W-1:0] c_L1_OUT_LAST = OUT_W'(L1_OUTS - 1);
    localparam logic [OUT_W-1:0] c_L2_OUT_LAST = OUT_W'(L2_OUTS - 1);

    state_t               r_state;
    logic [1:0]           r_layer;
    logic [TAP_W-1:0]     r_tap;
    logic [OUT_W-1:0]     r_out;
    logic [c_DRAIN_W-1:0] r_drain;

    state_t               w_state_nxt;
    logic [1:0]           w_layer_nxt;
    logic [TAP_W-1:0]     w_tap_nxt;
    logic [OUT_W-1:0]     w_out_nxt;
    logic [c_DRAIN_W-1:0] w_drain_nxt;
    logic [TAP_W-1:0]     w_tap_last;
    logic [OUT_W-1:0]     w_out_last;

    // Terminal tap/output index for the layer currently being processed
    always_comb begin
        w_tap_last = c_L2_TAP_LAST;
        w_out_last = c_L2_OUT_LAST;
        case (r_layer)
            LAYER_CONV1: begin
                w_tap_last = c_L0_TAP_LAST;
                w_out_last = c_L0_OUT_LAST;
            end
            LAYER_CONV2: begin
                w_tap_last = c_L1_TAP_LAST;
                w_out_last = c_L1_OUT_LAST;
            end
            default: begin
                w_tap_last = c_L2_TAP_LAST;
                w_out_last = c_L2_OUT_LAST;
            end
        endcase
    end

    // State, layer and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_layer <= LAYER_CONV1;
            r_tap   <= '0;
            r_out   <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_layer <= w_layer_nxt;
            r_tap   <= w_tap_nxt;
            r_out   <= w_out_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state/counter logic and state-decoded outputs; abort overrides all
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        w_tap_nxt   = r_tap;
        w_out_nxt   = r_out;
        w_drain_nxt = r_drain;

        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        mac_clr   = (r_state == CLEAR);
        mac_en    = (r_state == ACCUM) && op_valid;
        res_we    = (r_state == WRITE);
        mac_layer = r_layer;
        tap_idx   = r_tap;
        out_idx   = r_out;
        res_addr  = r_out;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = CLEAR;
                    w_layer_nxt = LAYER_CONV1;
                    w_out_nxt   = '0;
                    w_tap_nxt   = '0;
                end
            end
            CLEAR: begin
                w_tap_nxt   = '0;
                w_drain_nxt = '0;
                w_state_nxt = ACCUM;
            end
            ACCUM: begin
                // Tap index parks on the last tap rather than wrapping
                if (op_valid) begin
                    if (r_tap == w_tap_last) begin
                        w_state_nxt = c_AFTER_ACCUM;
                    end else begin
                        w_tap_nxt = r_tap + TAP_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_drain_nxt = r_drain + c_DRAIN_W'(1);
                end
            end
            WRITE: begin
                // Layer only advances here so post-MAC data under res_we
                // always belongs to the layer shown on mac_layer
                if (res_rdy) begin
                    w_tap_nxt = '0;
                    if (r_out != w_out_last) begin
                        w_out_nxt   = r_out + OUT_W'(1);
                        w_state_nxt = CLEAR;
                    end else if (r_layer != LAYER_FC) begin
                        w_layer_nxt = r_layer + 2'd1;
                        w_out_nxt   = '0;
                        w_state_nxt = CLEAR;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_layer_nxt = LAYER_CONV1;
                w_out_nxt   = '0;
                w_tap_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt = IDLE;
            w_layer_nxt = LAYER_CONV1;
            w_tap_nxt   = '0;
            w_out_nxt   = '0;
            w_drain_nxt = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_sequencer
// Description : Self-checking bench for mac_sequencer with reduced layer
//               sizes (OUTS=2, TAPS=3); one instance with MAC_LAT=2 and one
//               with MAC_LAT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int c_TAP_W = 8;
    localparam int c_OUT_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, start, abort, op_valid, res_rdy;
    logic               busy, done, mac_clr, mac_en, res_we;
    logic [1:0]         mac_layer;
    logic [c_TAP_W-1:0] tap_idx;
    logic [c_OUT_W-1:0] out_idx, res_addr;

    logic               start0, abort0, op_valid0, res_rdy0;
    logic               busy0, done0, mac_clr0, mac_en0, res_we0;
    logic [1:0]         mac_layer0;
    logic [c_TAP_W-1:0] tap_idx0;
    logic [c_OUT_W-1:0] out_idx0, res_addr0;

    mac_sequencer #(
        .L0_OUTS(2), .L0_TAPS(3), .L1_OUTS(2), .L1_TAPS(3),
        .L2_OUTS(2), .L2_TAPS(3), .MAC_LAT(2), .TAP_W(c_TAP_W), .OUT_W(c_OUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mac_layer(mac_layer), .mac_clr(mac_clr),
        .mac_en(mac_en), .tap_idx(tap_idx), .out_idx(out_idx),
        .op_valid(op_valid), .res_we(res_we), .res_rdy(res_rdy),
        .res_addr(res_addr)
    );

    mac_sequencer #(
        .L0_OUTS(2), .L0_TAPS(3), .L1_OUTS(2), .L1_TAPS(3),
        .L2_OUTS(2), .L2_TAPS(3), .MAC_LAT(0), .TAP_W(c_TAP_W), .OUT_W(c_OUT_W)
    ) dut_lat0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .mac_layer(mac_layer0), .mac_clr(mac_clr0),
        .mac_en(mac_en0), .tap_idx(tap_idx0), .out_idx(out_idx0),
        .op_valid(op_valid0), .res_we(res_we0), .res_rdy(res_rdy0),
        .res_addr(res_addr0)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Packed view {busy,done,clr,en,we,layer[1:0],tap[1:0],out[1:0],addr[1:0]}
    function automatic logic [12:0] pk(input logic b, input logic d, input logic c,
                                       input logic e, input logic w, input logic [1:0] l,
                                       input logic [1:0] t, input logic [1:0] o);
        return {b, d, c, e, w, l, t, o, o};
    endfunction

    typedef struct {
        logic        st;
        logic        ov;
        logic        rdy;
        logic        ab;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[18];

    // Wait up to a bound for the first write after a start; returns its cycle
    task automatic wait_write(output int k, output logic [1:0] lay, output logic [c_OUT_W-1:0] addr);
        k = -1;
        lay = 2'b11;
        addr = '1;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            start = 1'b0;
            #1;
            if (res_we) begin
                k = i;
                lay = mac_layer;
                addr = res_addr;
                break;
            end
        end
    endtask

    initial begin
        int         k_we[8];
        logic [1:0] lay_we[8];
        int         addr_we[8];
        int         n_we, n_busy, n_done, k_done, k;
        logic [1:0] lay;
        logic [c_OUT_W-1:0] addr;
        logic       prev_last, found;
        int         n_follow;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0; res_rdy = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; op_valid0 = 1'b1; res_rdy0 = 1'b1;

        // Reset state
        cyc();
        #1;
        chk("reset_state", 32'(pk(busy, done, mac_clr, mac_en, res_we, mac_layer,
                                  tap_idx[1:0], out_idx[1:0])), 32'(pk(0,0,0,0,0,0,0,0)));
        chk("reset_upper", 32'({tap_idx[7:2], out_idx[9:2], res_addr}), 32'd0);
        cyc();
        reset_n = 1'b1;

        // Stalls, res_rdy back-pressure, start-while-busy, abort from ACCUM
        //                st  ov  rdy ab      busy done clr en we lay tap out
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, pk(0,0,0,0,0,0,0,0)}; // IDLE, start
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0, pk(1,0,1,0,0,0,0,0)}; // CLEAR
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, pk(1,0,0,0,0,0,0,0)}; // stall
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,1,0,0,0,0)};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, pk(1,0,0,0,0,0,1,0)};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,1,0,0,1,0)};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, pk(1,0,0,0,0,0,2,0)};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,1,0,0,2,0)}; // last tap
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,0,0,2,0)}; // DRAIN
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,0,0,2,0)}; // DRAIN
        vecs[10] = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,1,0,2,0)}; // WRITE, not ready
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,1,0,2,0)};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,1,0,2,0)};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b0, pk(1,0,0,0,1,0,2,0)};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b0, pk(1,0,0,0,1,0,2,0)}; // accepted
        vecs[15] = '{1'b1,1'b1,1'b1,1'b0, pk(1,0,1,0,0,0,0,1)}; // CLEAR out 1
        vecs[16] = '{1'b0,1'b1,1'b1,1'b1, pk(1,0,0,1,0,0,0,1)}; // abort
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0, pk(0,0,0,0,0,0,0,0)}; // IDLE

        for (int i = 0; i < 18; i++) begin
            cyc();
            start = vecs[i].st; op_valid = vecs[i].ov; res_rdy = vecs[i].rdy; abort = vecs[i].ab;
            #1;
            checks++;
            if (pk(busy, done, mac_clr, mac_en, res_we, mac_layer, tap_idx[1:0], out_idx[1:0])
                    !== vecs[i].exp || res_addr[1:0] !== out_idx[1:0]) begin
                errors++;
                $display("FAIL vec%0d: got %b expected %b", i,
                         pk(busy, done, mac_clr, mac_en, res_we, mac_layer, tap_idx[1:0], out_idx[1:0]),
                         vecs[i].exp);
            end
        end
        start = 1'b0; abort = 1'b0;

        // Full pass with operands and sink always ready
        op_valid = 1'b1; res_rdy = 1'b1;
        cyc();
        start = 1'b1;
        n_we = 0; n_busy = 0; n_done = 0; k_done = -1;
        for (int i = 1; i <= 80; i++) begin
            cyc();
            start = 1'b0;
            #1;
            if (busy) n_busy++;
            if (done) begin n_done++; k_done = i; end
            if (res_we) begin
                if (n_we < 8) begin
                    k_we[n_we] = i; lay_we[n_we] = mac_layer; addr_we[n_we] = int'(res_addr);
                end
                n_we++;
            end
        end
        chk("pass_writes", 32'(n_we), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("pass_we%0d_cycle", i), 32'(k_we[i]), 32'(7 * (i + 1)));
            chk($sformatf("pass_we%0d_layer", i), 32'(lay_we[i]), 32'(i / 2));
            chk($sformatf("pass_we%0d_addr", i), 32'(addr_we[i]), 32'(i % 2));
        end
        chk("pass_done_cycle", 32'(k_done), 32'd43);
        chk("pass_done_count", 32'(n_done), 32'd1);
        chk("pass_busy_cycles", 32'(n_busy), 32'd43);

        // Abort in DRAIN of conv2 output 1
        cyc();
        start = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            start = 1'b0;
            #1;
            if (busy && mac_layer == 2'b01 && out_idx == 1 && !mac_en && !mac_clr && !res_we) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_drain_reached", 32'(found), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        chk("abort_idle", 32'({busy, done, res_we, mac_layer, out_idx[1:0], tap_idx[1:0]}), 32'd0);
        n_we = 0; n_done = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if (res_we) n_we++;
            if (done) n_done++;
        end
        chk("abort_no_writes", 32'(n_we + n_done), 32'd0);
        start = 1'b1;
        wait_write(k, lay, addr);
        chk("restart_we_cycle", 32'(k), 32'd7);
        chk("restart_we_layer_addr", 32'({lay, addr}), 32'd0);

        // Asynchronous reset in ACCUM, checked before the next edge
        start = 1'b0; abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        start = 1'b1;
        cyc(); start = 1'b0;  // CLEAR
        cyc();                // ACCUM tap 0
        cyc();                // ACCUM tap 1
        #1;
        chk("pre_reset_accum", 32'({mac_en, tap_idx[1:0]}), 32'b1_01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({busy, mac_en, mac_clr, res_we, tap_idx, out_idx, mac_layer}), 32'd0);
        cyc();
        reset_n = 1'b1;
        start = 1'b1;
        wait_write(k, lay, addr);
        chk("post_reset_we_cycle", 32'(k), 32'd7);
        chk("post_reset_we_layer_addr", 32'({lay, addr}), 32'd0);

        // MAC_LAT=0 instance: WRITE straight after the last ACCUM cycle
        cyc();
        start0 = 1'b1;
        n_we = 0; n_busy = 0; n_follow = 0; k_done = -1; k_we[0] = -1;
        prev_last = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            cyc();
            start0 = 1'b0;
            #1;
            if (busy0) n_busy++;
            if (prev_last && res_we0) n_follow++;
            if (res_we0) begin
                if (n_we == 0) k_we[0] = i;
                n_we++;
            end
            prev_last = mac_en0 && (tap_idx0 == 2);
        end
        chk("lat0_first_we_cycle", 32'(k_we[0]), 32'd5);
        chk("lat0_writes", 32'(n_we), 32'd6);
        chk("lat0_we_follows_accum", 32'(n_follow), 32'd6);
        chk("lat0_busy_cycles", 32'(n_busy), 32'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Control FSM that drives the shared 6-lane MAC array and its post-MAC bias/ReLU/shift stage through the three network layers in order: conv1, then conv2, then FC. For each output position it clears the accumulators and streams the tap indices while operands are valid. It then waits out the MAC pipeline latency and issues one result write per output. It sits between the top-level Avalon control registers (start/done) and the MAC datapath and operand/result memories.

Parameters:
L0_OUTS, 576, conv1 output positions (24x24); 6 channels computed in parallel per position
L0_TAPS, 25, conv1 taps per output (5x5 kernel)
L1_OUTS, 64, conv2 output positions
L1_TAPS, 25, conv2 taps per lane per output; lanes summed downstream
L2_OUTS, 2, FC output groups (6 lanes per group, 10 logits)
L2_TAPS, 192, FC inputs per output
MAC_LAT, 2, cycles from last mac_en to valid MAC outputs (0 allowed)
TAP_W, 8, tap index width (must hold max TAPS-1)
OUT_W, 10, output index width (must hold max OUTS-1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin full 3-layer pass; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion of FC layer
mac_layer  out  2  layer select to MAC and post-MAC stage: 00 conv1, 01 conv2, 10 FC
mac_clr  out  1  clear accumulators
mac_en  out  1  accumulate current operands
tap_idx  out  TAP_W  tap address to weight/pixel fetch
out_idx  out  OUT_W  current output position/group
op_valid  in  1  fetched operands for tap_idx are valid this cycle
res_we  out  1  result write request; post-MAC outputs valid
res_rdy  in  1  result sink accepts the write
res_addr  out  OUT_W  write address; equals out_idx

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy, done, mac_clr, mac_en, res_we=0; mac_layer=00; tap_idx=0; out_idx=0.
- IDLE: outputs as at reset. start=1 -> CLEAR next cycle with layer=00 and out_idx=0. start is ignored in all other states.
- CLEAR: mac_clr=1 for exactly one cycle; tap_idx=0 -> ACCUM.
- ACCUM: mac_en=op_valid combinationally.
  - op_valid=1: tap_idx increments.
  - op_valid=1 with tap_idx==TAPS(layer)-1: go to DRAIN (or WRITE if MAC_LAT=0); tap_idx holds at TAPS-1.
  - op_valid=0: stall; mac_en=0 and tap_idx holds.
- DRAIN: count exactly MAC_LAT cycles, mac_en=0 -> WRITE.
- WRITE: res_we=1 held until res_rdy=1; write completes in the cycle res_we and res_rdy are both 1.
  - On completion with out_idx<OUTS(layer)-1: out_idx+1 -> CLEAR.
  - On completion with out_idx==OUTS-1 and layer<10: layer+1, out_idx=0 -> CLEAR.
  - On completion with layer==10: -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- mac_layer is registered and constant for a whole layer. It changes only on the WRITE->CLEAR transition, so post-MAC outputs sampled during res_we always match mac_layer. Value 11 is never driven.
- Cycles per output with op_valid and res_rdy tied high: 1 (CLEAR) + TAPS + MAC_LAT + 1 (WRITE).
- abort=1 in any state: next state IDLE with all outputs at reset values. No done pulse, and any pending write is dropped. abort has priority over start, op_valid and res_rdy.
- Reset asserted mid-layer: immediate return to reset values. A later start restarts from conv1, out_idx 0.
- Counter comparisons use per-layer constants selected by mac_layer. Indices never wrap past TAPS-1 or OUTS-1.

Decomposition:
- Shared package mac_seq_pkg holds:
  - layer encodings LAYER_CONV1=2'b00, LAYER_CONV2=2'b01, LAYER_FC=2'b10, also used by the post-MAC stage;
  - state enum IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE;
  - default layer dimension constants.
- No sub-module. FSM, tap counter, drain counter and output counter stay in one module.

Test Plan:
- Params L0/L1/L2 OUTS=2, TAPS=3, MAC_LAT=2; op_valid=res_rdy=1; start pulse -> 6 res_we pulses, 7 cycles apart (1+3+2+1); res_addr 0,1 per layer; mac_layer 00,00,01,01,10,10; done one cycle after last write; 43 busy cycles.
- Same params, op_valid low on every other cycle in ACCUM -> mac_en mirrors op_valid; tap_idx holds during stalls; each output takes 3 extra cycles; write count unchanged.
- res_rdy held low 4 cycles at the first WRITE -> res_we stays high, res_addr=0 stable, out_idx unchanged until res_rdy=1; then CLEAR.
- abort asserted in DRAIN of conv2 output 1 -> next cycle IDLE, busy=0, no done, no further res_we; new start -> first write has mac_layer=00, res_addr=0.
- reset_n pulsed low mid-ACCUM, asynchronously between clock edges -> outputs reach reset values before the next edge; start while busy is ignored; MAC_LAT=0 -> WRITE immediately follows the last ACCUM cycle.
